// File: rtl/branch_direction_predictor.sv
// branch_direction_predictor: gshare taken/not-taken predictor for the fetch stage.
//   Lookup is combinational: the PHT index is the fetch PC word address XORed with the
//   global history register (GHR). The GHR is shifted speculatively on predicted branches at
//   fetch and rebuilt from the EX-stage snapshot on a mispredict. The 2-bit PHT counters are
//   trained when a branch resolves in EX.
// Ports:
//   clk, rst         rising-edge clock; asynchronous active-low reset
//   PC_F             fetch PC
//   read_en          prediction lookup enable
//   BTB_Hit_F        BTB reports a branch at PC_F
//   Stall_F          fetch stalled (suppresses the speculative GHR shift)
//   Predict_Taken    predicted direction for PC_F
//   Pred_Index_F     PHT index used, carried to EX
//   GHR_F            GHR before this fetch's update, carried to EX
//   write_en         branch resolved in EX this cycle
//   Index_EX         PHT index of the resolving branch
//   GHR_EX           GHR snapshot of the resolving branch
//   Branch_Taken_EX  actual outcome
//   Mispredict_EX    mispredict flag, qualified by write_en
//   Mispredict_Cnt   saturating mispredict count
module branch_direction_predictor #(
    parameter int          PHT_ENTRIES = 256,
    parameter int          GHR_BITS    = $clog2(PHT_ENTRIES),
    parameter logic [1:0]  CTR_INIT    = 2'b01,
    parameter int          CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         PC_F,
    input  logic                read_en,
    input  logic                BTB_Hit_F,
    input  logic                Stall_F,
    output logic                Predict_Taken,
    output logic [GHR_BITS-1:0] Pred_Index_F,
    output logic [GHR_BITS-1:0] GHR_F,
    input  logic                write_en,
    input  logic [GHR_BITS-1:0] Index_EX,
    input  logic [GHR_BITS-1:0] GHR_EX,
    input  logic                Branch_Taken_EX,
    input  logic                Mispredict_EX,
    output logic [CNT_BITS-1:0] Mispredict_Cnt
);
    logic [1:0]          r_pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0] r_ghr;
    logic [CNT_BITS-1:0] r_cnt;
    logic [GHR_BITS-1:0] w_idx;
    logic [1:0]          w_ctr;
    logic [1:0]          w_ctr_next;
    logic                w_spec;
    logic                w_rec;
    logic [GHR_BITS-1:0] w_ghr_next;

    always_comb begin
        w_idx      = PC_F[GHR_BITS+1:2] ^ r_ghr;
        w_ctr      = r_pht[Index_EX];
        w_ctr_next = Branch_Taken_EX ? ((w_ctr == 2'b11) ? w_ctr : w_ctr + 2'd1)
                                     : ((w_ctr == 2'b00) ? w_ctr : w_ctr - 2'd1);
        w_spec     = read_en & BTB_Hit_F & ~Stall_F;
        w_rec      = write_en & Mispredict_EX;
        // Recovery wins over speculation: the fetch in that cycle is squashed anyway.
        w_ghr_next = w_rec  ? {GHR_EX[GHR_BITS-2:0], Branch_Taken_EX} :
                     w_spec ? {r_ghr[GHR_BITS-2:0], Predict_Taken} : r_ghr;
    end

    assign Predict_Taken  = read_en & r_pht[w_idx][1];
    assign Pred_Index_F   = w_idx;
    assign GHR_F          = r_ghr;
    assign Mispredict_Cnt = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= CTR_INIT;
            r_ghr <= '0;
            r_cnt <= '0;
        end else begin
            if (write_en) r_pht[Index_EX] <= w_ctr_next;
            r_ghr <= w_ghr_next;
            if (w_rec && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
